// File: rtl/blink_rate_sequencer.sv
// blink_rate_sequencer
//   LED blink-rate scheduler. The 2-bit switch select is synchronised
//   (and optionally debounced). One shared prescale counter produces the
//   LED square wave. A new rate takes effect only on the led 1->0 toggle,
//   so a rate change never truncates a pulse.
//
//   Optional feature macro: BLINK_DEBOUNCE_EN
//     defined   - sw_sync must hold for DB_CYCLES cycles before it is accepted
//     undefined - sw_sync is accepted every cycle; no debounce logic is built
//
// Parameters
//   BASE_HALF  half-period in sysclk cycles for rate 00 (>= 2)
//   SHIFT      log2 slowdown per rate step: HALF(r) = BASE_HALF << (SHIFT*r)
//   CNT_W      prescale counter width; HALF(3) must fit in 2**CNT_W
//   DB_CYCLES  debounce window (used only with BLINK_DEBOUNCE_EN, >= 1)
//
// Ports
//   sysclk        in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   sw[1:0]       in   asynchronous rate select, 00 fastest .. 11 slowest
//   led           out  50% duty square wave
//   rate_active   out  rate currently driving led
//   rate_pending  out  a requested rate is waiting for the period boundary
//   period_tick   out  one-cycle pulse on every led toggle
module blink_rate_sequencer #(
    parameter int unsigned BASE_HALF = 16,
    parameter int unsigned SHIFT     = 1,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned DB_CYCLES = 8
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [1:0] sw,
    output logic       led,
    output logic [1:0] rate_active,
    output logic       rate_pending,
    output logic       period_tick
);

    if (BASE_HALF < 2 || DB_CYCLES < 1) begin : g_param_check
        $error("blink_rate_sequencer: BASE_HALF must be >= 2 and DB_CYCLES >= 1");
    end

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       sw_meta;
    logic [1:0]       sw_sync;
    logic [1:0]       sw_stable;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic             wrap;
    logic             boundary;
    logic             mismatch;

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

`ifdef BLINK_DEBOUNCE_EN
    localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [DB_W-1:0] db_cnt;

    // sw_meta != sw_sync means sw_sync takes a new value on this edge, so the
    // hold count restarts here; the value is accepted on the DB_CYCLES-th edge
    // it has been present on sw_sync.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt    <= '0;
            sw_stable <= '0;
        end else if (sw_meta != sw_sync) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            sw_stable <= sw_sync;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end
`else
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sw_stable <= '0;
        end else begin
            sw_stable <= sw_sync;
        end
    end
`endif

    // Half-period depends only on the applied rate. When HALF equals 2**CNT_W
    // it truncates to zero and half-1 becomes all ones, which still wraps
    // at the right count.
    always_comb begin
        half     = CNT_W'(BASE_HALF) << (SHIFT * 32'(rate_active));
        wrap     = (cnt == half - CNT_W'(1));
        boundary = wrap & led;
        mismatch = (sw_stable != rate_active);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            cnt          <= '0;
            led          <= 1'b0;
            period_tick  <= 1'b0;
            rate_active  <= 2'b00;
            rate_pending <= 1'b0;
        end else begin
            if (wrap) begin
                cnt         <= '0;
                led         <= ~led;
                period_tick <= 1'b1;
            end else begin
                cnt         <= cnt + CNT_W'(1);
                period_tick <= 1'b0;
            end

            unique case (state)
                RUN: begin
                    if (mismatch) begin
                        // A request that becomes visible exactly on a 1->0
                        // wrap is applied at that boundary without a
                        // pending phase.
                        if (boundary) begin
                            rate_active <= sw_stable;
                        end else begin
                            state        <= PENDING;
                            rate_pending <= 1'b1;
                        end
                    end
                end
                PENDING: begin
                    if (!mismatch) begin
                        state        <= RUN;
                        rate_pending <= 1'b0;
                    end else if (boundary) begin
                        rate_active  <= sw_stable;
                        state        <= RUN;
                        rate_pending <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_rate_sequencer.sv
// tb_blink_rate_sequencer
//   Directed bench for blink_rate_sequencer with BASE_HALF=4, SHIFT=1,
//   DB_CYCLES=4. Expected led toggles (interval, level, rate) are queued as
//   stimulus is applied and checked whenever period_tick pulses. Pending and
//   rate timing is derived from the request latency of the selected build.
module tb_blink_rate_sequencer;

    localparam int unsigned DB = 4;
`ifdef BLINK_DEBOUNCE_EN
    localparam int LAT      = 2 + DB;
    localparam bit DEBOUNCE = 1'b1;
`else
    localparam int LAT      = 3;
    localparam bit DEBOUNCE = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic [1:0] sw     = 2'b00;
    logic       led;
    logic [1:0] rate_active;
    logic       rate_pending;
    logic       period_tick;

    int checks = 0;
    int errors = 0;
    int cyc;
    int last_tick = 0;

    typedef struct {
        int         interval;
        logic       lvl;
        logic [1:0] rate;
    } tog_t;

    tog_t exp_q[$];
    tog_t mt;
    logic exp_led = 1'b0;

    blink_rate_sequencer #(
        .BASE_HALF(4),
        .SHIFT    (1),
        .CNT_W    (16),
        .DB_CYCLES(DB)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .sw          (sw),
        .led         (led),
        .rate_active (rate_active),
        .rate_pending(rate_pending),
        .period_tick (period_tick)
    );

    always #5 sysclk = ~sysclk;

    // Edge count since reset release: cyc == k at the negedge after edge k
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_toggles(input int n, input int interval, input logic [1:0] rate);
        tog_t t;
        for (int i = 0; i < n; i++) begin
            exp_led    = ~exp_led;
            t.interval = interval;
            t.lvl      = exp_led;
            t.rate     = rate;
            exp_q.push_back(t);
        end
    endtask

    task automatic wait_edge(input int k);
        while (cyc < k) @(negedge sysclk);
    endtask

    // Toggle monitor: every period_tick pops one expected toggle
    always @(negedge sysclk) begin
        if (!rst_n) begin
            last_tick = 0;
        end else if (period_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("toggle_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                mt = exp_q.pop_front();
                check("toggle_interval", 32'(cyc - last_tick), 32'(mt.interval));
                check("toggle_led", 32'(led), 32'(mt.lvl));
                check("toggle_rate", 32'(rate_active), 32'(mt.rate));
            end
            last_tick = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         a;
        int         b;
        int         n5;
        logic [1:0] rexp;
        logic       pexp;

        // Reset state
        repeat (3) @(negedge sysclk);
        check("rst_led", 32'(led), 32'd0);
        check("rst_rate", 32'(rate_active), 32'd0);
        check("rst_pending", 32'(rate_pending), 32'd0);
        check("rst_tick", 32'(period_tick), 32'd0);
        rst_n = 1'b1;

        // 1: rate 00, led toggles every 4 cycles
        push_toggles(4, 4, 2'b00);
        for (int e = 1; e <= 17; e++) begin
            wait_edge(e);
            check("t1_pending", 32'(rate_pending), 32'd0);
            check("t1_rate", 32'(rate_active), 32'd0);
        end

        // 2: sw 00->10 mid-period; applied at the next led 1->0 boundary
        wait_edge(18);
        a = ((18 + LAT) / 8 + 1) * 8;
        push_toggles((a - 20) / 4, 4, 2'b00);
        push_toggles(1, 4, 2'b10);
        push_toggles(2, 16, 2'b10);
        sw = 2'b10;
        for (int e = 19; e <= a + 1; e++) begin
            wait_edge(e);
            pexp = (e >= 18 + LAT + 1) && (e < a);
            rexp = (e >= a) ? 2'b10 : 2'b00;
            check("t2_pending", 32'(rate_pending), 32'(pexp));
            check("t2_rate", 32'(rate_active), 32'(rexp));
        end

        // 3: two-cycle glitch 10->11->10
        wait_edge(a + 34);
        push_toggles(1, 16, 2'b10);
        sw = 2'b11;
        for (int e = a + 35; e <= a + 47; e++) begin
            wait_edge(e);
            pexp = DEBOUNCE ? 1'b0 : ((e >= a + 38) && (e <= a + 39));
            check("t3_pending", 32'(rate_pending), 32'(pexp));
            check("t3_rate", 32'(rate_active), 32'd2);
            if (e == a + 36) sw = 2'b10;
        end

        // 4: cancel 10->11->10 before the boundary, period stays 16
        wait_edge(a + 49);
        push_toggles(2, 16, 2'b10);
        sw = 2'b11;
        for (int e = a + 50; e <= a + 65; e++) begin
            wait_edge(e);
            pexp = (e >= a + 49 + LAT + 1) && (e <= a + 55 + LAT);
            check("t4_pending", 32'(rate_pending), 32'(pexp));
            check("t4_rate", 32'(rate_active), 32'd2);
            if (e == a + 55) sw = 2'b10;
        end

        // 5: request becomes visible exactly on the 1->0 wrap cycle
        b  = a + 96;
        n5 = b - 1 - LAT;
        wait_edge(n5);
        push_toggles(1, 16, 2'b11);
        push_toggles(1, 32, 2'b11);
        sw = 2'b11;
        for (int e = n5 + 1; e <= b + 1; e++) begin
            wait_edge(e);
            rexp = (e >= b) ? 2'b11 : 2'b10;
            check("t5_pending", 32'(rate_pending), 32'd0);
            check("t5_rate", 32'(rate_active), 32'(rexp));
        end

        // 6: reset while pending with led high
        wait_edge(b + 33);
        sw = 2'b10;
        for (int e = b + 34; e <= b + 42; e++) begin
            wait_edge(e);
            check("t6_pending", 32'(rate_pending), 32'(e >= b + 34 + LAT));
            check("t6_rate", 32'(rate_active), 32'd3);
        end
        check("t6_led_high", 32'(led), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_led", 32'(led), 32'd0);
        check("t6_async_rate", 32'(rate_active), 32'd0);
        check("t6_async_pending", 32'(rate_pending), 32'd0);
        check("t6_async_tick", 32'(period_tick), 32'd0);
        check("t6_queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge sysclk);
        rst_n   = 1'b1;
        exp_led = 1'b0;
        push_toggles(1, 4, 2'b00);
        push_toggles(1, 4, 2'b10);
        push_toggles(2, 16, 2'b10);
        for (int e = 1; e <= 9; e++) begin
            wait_edge(e);
            pexp = (e >= LAT + 1) && (e < 8);
            rexp = (e >= 8) ? 2'b10 : 2'b00;
            check("t6_re_pending", 32'(rate_pending), 32'(pexp));
            check("t6_re_rate", 32'(rate_active), 32'(rexp));
        end
        wait_edge(41);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
